divu_seq: RTL and testbench
===========================

# divu_seq

Sequential 32-bit unsigned divider executing the DIVU operation (funct 27) alongside the ALU's shift-add multiplier. It consumes the same `dataA`/`dataB` operands, runs one restoring-division step per clock, and emits quotient and remainder with a one-cycle `done` strobe. That strobe is the write enable for the Hi/Lo register pair: Lo takes the quotient and Hi takes the remainder, so MFHI (16) and MFLO (18) read the result exactly as they do after MULTU (25).

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  reset, asynchronous and active-low. One clock; reset asserts without a clock edge.
- `start`  in  1  request a division. Sampled only when `busy`=0.
- `dataA`  in  WIDTH  dividend, captured on the accepting edge.
- `dataB`  in  WIDTH  divisor, captured on the accepting edge.
- `busy`  out  1  high in CALC and DONE states.
- `done`  out  1  one-cycle pulse when a result becomes valid; Hi/Lo write enable.
- `quotient`  out  WIDTH  Lo value; held until the next `done`.
- `remainder`  out  WIDTH  Hi value; held until the next `done`.
- `div_zero`  out  1  set with `done` when the divisor was 0; held with the results.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE.** On `start`=1 at a rising edge, latch the divisor and set the working registers: `rem`=0, `quo`=`dataA`, `cnt`=0.
  - If `dataB`≠0, go to CALC.
  - If `dataB`=0, go straight to DONE.
- **CALC**, once per edge:
  - Form `{rem,quo}` shifted left by 1 into `rem_s` and `quo_s`.
  - Compute `diff = rem_s − divisor` at WIDTH+1 bits.
  - If `diff` is not negative: `rem`←`diff[WIDTH-1:0]` and `quo`←`quo_s`|1.
  - Otherwise: `rem`←`rem_s` and `quo`←`quo_s`.
  - `cnt`←`cnt`+1. `cnt` is $clog2(WIDTH)+1 bits wide so it never wraps.
  - On the edge where `cnt`=WIDTH−1, go to DONE and load the outputs: `quotient`←final `quo`, `remainder`←final `rem`, `div_zero`←0.
- **Divide-by-zero path.** On entry to DONE: `quotient`←all ones, `remainder`←dividend, `div_zero`←1.
- **DONE.** `done`=1 for this single cycle. Unconditionally go to IDLE on the next edge.
- **Start while busy.** `start` in CALC or DONE is ignored. It is not queued, and operands are not re-sampled.
- **Operand changes.** `dataA`/`dataB` changing after the accepting edge has no effect on the result.
- **Unsigned only.** Signed DIV is out of scope.
- **Reset,** asserted at any time including mid-CALC:
  - State goes to IDLE.
  - `busy`, `done`, `div_zero`, `quotient`, `remainder` and all working registers go to 0.
  - The next `start` after deassertion is accepted normally.

## Timing
- Accepting edge is E0.
- **Normal division:**
  - CALC occupies edges E1..E32.
  - Outputs update on E32.
  - `done`=1 between E32 and E33.
  - IDLE again at E33.
  - Result is valid 32 cycles after E0, within the 33-cycle budget the bench already allots to MULTU.
- **Divide by zero:**
  - DONE is entered at E0.
  - Outputs update on E0.
  - `done`=1 between E0 and E1.
  - IDLE at E1.
- `busy` is registered. It rises right after E0 and falls right after the edge that leaves DONE.
- Earliest next acceptance is the edge following `done`, so back-to-back divisions are spaced 33 cycles apart (normal) or 1 idle cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Normal case.** Reset low for 2 cycles, then high. `start` with `dataA`=100, `dataB`=7.
  - `done` exactly 32 cycles after the accept edge.
  - `quotient`=14, `remainder`=2, `div_zero`=0.
  - `busy` low on the following cycle.
- **Extremes.**
  - `dataA`=0xFFFFFFFF, `dataB`=1 → `quotient`=0xFFFFFFFF, `remainder`=0.
  - Then `dataA`=0xFFFFFFFF, `dataB`=0xFFFFFFFF → `quotient`=1, `remainder`=0.
- **Dividend below divisor.** `dataA`=3, `dataB`=10 → `quotient`=0, `remainder`=3, after 32 cycles.
- **Divide by zero.** `dataA`=5, `dataB`=0.
  - `done` one cycle after accept.
  - `quotient`=0xFFFFFFFF, `remainder`=5, `div_zero`=1.
  - A following 9/3 request returns 3/0 with `div_zero`=0.
- **Start ignored while busy.** Start 50/4, then pulse `start` with 99/9 at cycles 5 and 32.
  - Only one `done` occurs, with `quotient`=12, `remainder`=2.
  - The outputs hold those values afterwards.
- **Reset mid-operation.** Start 1000/3, then assert `rst_n`=0 asynchronously mid-cycle 10.
  - All outputs and `busy` are 0 immediately.
  - After release, 1000/3 yields `quotient`=333, `remainder`=1 at 32 cycles.

Source files
------------

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, result
// presented with a one-cycle done strobe that serves as the Hi/Lo write enable.
module divu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   rem_s;
   logic [WIDTH-1:0] quo_s;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;

   // rem_s keeps the bit shifted out of rem so divisors near 2^WIDTH still
   // compare correctly; with rem < divisor the sign of diff is its top bit.
   always_comb begin
      rem_s = {rem, quo[WIDTH-1]};
      quo_s = {quo[WIDTH-2:0], 1'b0};
      diff  = rem_s - {1'b0, divisor};
      rem_n = rem_s[WIDTH-1:0];
      quo_n = quo_s;
      if (!diff[WIDTH]) begin
         rem_n = diff[WIDTH-1:0];
         quo_n = quo_s | {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         divisor   <= '0;
         rem       <= '0;
         quo       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  divisor <= dataB;
                  rem     <= '0;
                  quo     <= dataA;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  if (dataB != '0) begin
                     state <= S_CALC;
                  end else begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     quotient  <= '1;
                     remainder <= dataA;
                     div_zero  <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  quotient  <= quo_n;
                  remainder <= rem_n;
                  div_zero  <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divu_seq.sv
// Bench for divu_seq: cycle-level reference built from plain / and % with an
// edge countdown, plus directed cases with hand-computed results.
module tb_divu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   divu_seq #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .dataA(dataA),
      .dataB(dataB),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [127:0] pack(input logic b, input logic d, input logic z,
                                         input logic [31:0] q, input logic [31:0] r);
      return {61'b0, b, d, z, q, r};
   endfunction

   // Reference: m_left counts edges until the divider is idle again.
   logic [5:0]  m_left = '0;
   logic        e_done = 1'b0;
   logic        e_dz = 1'b0;
   logic [31:0] e_q = '0;
   logic [31:0] e_r = '0;
   logic [31:0] pa = '0;
   logic [31:0] pb = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= '0;
         e_done <= 1'b0;
         e_dz   <= 1'b0;
         e_q    <= '0;
         e_r    <= '0;
      end else if (m_left == 0) begin
         e_done <= 1'b0;
         if (start) begin
            pa <= dataA;
            pb <= dataB;
            if (dataB == 0) begin
               m_left <= 6'd1;
               e_done <= 1'b1;
               e_q    <= 32'hFFFF_FFFF;
               e_r    <= dataA;
               e_dz   <= 1'b1;
            end else begin
               m_left <= 6'd33;
            end
         end
      end else begin
         m_left <= m_left - 6'd1;
         e_done <= 1'b0;
         if (m_left == 6'd2) begin
            e_done <= 1'b1;
            e_q    <= pa / pb;
            e_r    <= pa % pb;
            e_dz   <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("cycle", pack(busy, done, div_zero, quotient, remainder),
            pack(m_left != 0, e_done, e_dz, e_q, e_r));
   end

   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ez, input int unsigned elat);
      int unsigned lat;
      @(negedge clk);
      start = 1'b1;
      dataA = a;
      dataB = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      dataA = $urandom;
      dataB = $urandom;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 128'(lat), 128'(elat));
      check("quotient", 128'(quotient), 128'(eq));
      check("remainder", 128'(remainder), 128'(er));
      check("div_zero", 128'(div_zero), 128'(ez));
      @(posedge clk);
      #1;
      check("busy_after", 128'(busy), 128'(0));
   endtask

   initial begin
      int unsigned ndone;
      logic [31:0] a;
      logic [31:0] b;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", pack(busy, done, div_zero, quotient, remainder), pack(0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
      run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
      run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
      run_div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32);
      run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
      run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

      // start pulses during CALC and DONE must be dropped
      @(negedge clk);
      start = 1'b1;
      dataA = 32'd50;
      dataB = 32'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = (k == 5 || k == 32 || k == 33);
         dataA = 32'd99;
         dataB = 32'd9;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) ndone++;
      end
      check("single_done", 128'(ndone), 128'(1));
      check("busy_ignore_q", 128'(quotient), 128'(12));
      check("busy_ignore_r", 128'(remainder), 128'(2));

      // asynchronous reset in the middle of a division
      @(negedge clk);
      start = 1'b1;
      dataA = 32'd1000;
      dataB = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", pack(busy, done, div_zero, quotient, remainder), pack(0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 32);

      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if (b == 0)
            run_div(a, b, 32'hFFFF_FFFF, a, 1'b1, 0);
         else
            run_div(a, b, a / b, a % b, 1'b0, 32);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
